// File: rtl/lbist_pkg.sv
// Shared types for the LBIST sequencer: FSM state encoding and the
// bundle of registered control outputs, plus the state-to-output decode.
package lbist_pkg;

  localparam int STATE_W   = 3;
  localparam int SIG_W_DEF = 32;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_INIT,
    ST_WARMUP,
    ST_RUN,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic test_mode;
    logic tpg_load;
    logic tpg_en;
    logic misr_clr;
    logic misr_en;
    logic busy;
    logic started;
    logic finished;
    logic done;
  } ctrl_out_t;

  // Control outputs that belong to a state; registered alongside the state.
  function automatic ctrl_out_t decode_state(state_e s);
    ctrl_out_t o;
    o = '0;
    case (s)
      ST_INIT: begin
        o.test_mode = 1'b1;
        o.tpg_load  = 1'b1;
        o.misr_clr  = 1'b1;
        o.busy      = 1'b1;
      end
      ST_WARMUP: begin
        o.test_mode = 1'b1;
        o.tpg_en    = 1'b1;
        o.busy      = 1'b1;
        o.started   = 1'b1;
      end
      ST_RUN: begin
        o.test_mode = 1'b1;
        o.tpg_en    = 1'b1;
        o.misr_en   = 1'b1;
        o.busy      = 1'b1;
        o.started   = 1'b1;
      end
      ST_SETTLE: begin
        o.test_mode = 1'b1;
        o.misr_en   = 1'b1;
        o.busy      = 1'b1;
        o.started   = 1'b1;
        o.finished  = 1'b1;
      end
      ST_COMPARE: begin
        o.busy      = 1'b1;
        o.started   = 1'b1;
        o.finished  = 1'b1;
      end
      ST_DONE: begin
        o.started   = 1'b1;
        o.finished  = 1'b1;
        o.done      = 1'b1;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/lbist_phase_counter.sv
// Loadable down-counter with a zero flag. Times the warm-up and capture
// phases; it stops at zero instead of wrapping, the FSM reloads it there.
module lbist_phase_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_count;

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create ordering races.
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/lbist_controller.sv
// LBIST sequencer: seeds the TPG, clears the MISR, runs warm-up and capture
// phases, then compares the MISR signature against the golden value.
module lbist_controller
  import lbist_pkg::*;
#(
  parameter int              TEST_START    = 16,
  parameter int              TEST_DURATION = 1024,
  parameter int              CNT_W         = 16,
  parameter int              SIG_W         = SIG_W_DEF,
  parameter logic [SIG_W-1:0] GOLDEN_SIG    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [SIG_W-1:0] misr_sig_i,
  output logic             test_mode_o,
  output logic             tpg_load_o,
  output logic             tpg_en_o,
  output logic             misr_clr_o,
  output logic             misr_en_o,
  output logic             busy_o,
  output logic             test_started_o,
  output logic             test_finished_o,
  output logic             done_o,
  output logic             pass_o
);

  if (TEST_DURATION < 1) begin : g_bad_duration
    $error("lbist_controller: TEST_DURATION must be >= 1");
  end
  if ((longint'(TEST_START) >= (longint'(1) << CNT_W)) ||
      (longint'(TEST_DURATION) >= (longint'(1) << CNT_W))) begin : g_bad_cnt_w
    $error("lbist_controller: phase lengths do not fit CNT_W");
  end

  localparam bit               SKIP_WARMUP = (TEST_START == 0);
  localparam logic [CNT_W-1:0] WARMUP_LOAD = SKIP_WARMUP ? '0 : CNT_W'(TEST_START - 1);
  localparam logic [CNT_W-1:0] RUN_LOAD    = CNT_W'(TEST_DURATION - 1);

  state_e           r_state;
  state_e           w_nxt;
  ctrl_out_t        r_out;
  logic             r_pass;
  logic             w_cnt_load;
  logic             w_cnt_dec;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_zero;

  lbist_phase_counter #(
    .CNT_W (CNT_W)
  ) u_phase_counter (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // Phase counter control: load on INIT and on warm-up expiry, else count down.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_cnt_load = 1'b0;
    w_cnt_dec  = 1'b0;
    w_cnt_val  = RUN_LOAD;
    case (r_state)
      ST_INIT: begin
        w_cnt_load = 1'b1;
        w_cnt_val  = SKIP_WARMUP ? RUN_LOAD : WARMUP_LOAD;
      end
      ST_WARMUP: begin
        w_cnt_load = w_cnt_zero;
        w_cnt_dec  = ~w_cnt_zero;
      end
      ST_RUN: w_cnt_dec = ~w_cnt_zero;
      default: ;
    endcase
  end

  // Next-state logic; abort wins over start and over phase completion.
  always_comb begin
    w_nxt = r_state;
    if (abort_i) begin
      w_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:    if (start_i) w_nxt = ST_INIT;
        ST_INIT:    w_nxt = SKIP_WARMUP ? ST_RUN : ST_WARMUP;
        ST_WARMUP:  if (w_cnt_zero) w_nxt = ST_RUN;
        ST_RUN:     if (w_cnt_zero) w_nxt = ST_SETTLE;
        ST_SETTLE:  w_nxt = ST_COMPARE;
        ST_COMPARE: w_nxt = ST_DONE;
        ST_DONE:    if (start_i) w_nxt = ST_INIT;
        default:    w_nxt = ST_IDLE;
      endcase
    end
  end

  // State, registered outputs and pass flag; outputs track the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_pass  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_out   <= decode_state(w_nxt);
      if ((w_nxt == ST_IDLE) || (w_nxt == ST_INIT)) begin
        r_pass <= 1'b0;
      end else if (r_state == ST_COMPARE) begin
        r_pass <= (misr_sig_i == GOLDEN_SIG);
      end
    end
  end

  assign test_mode_o     = r_out.test_mode;
  assign tpg_load_o      = r_out.tpg_load;
  assign tpg_en_o        = r_out.tpg_en;
  assign misr_clr_o      = r_out.misr_clr;
  assign misr_en_o       = r_out.misr_en;
  assign busy_o          = r_out.busy;
  assign test_started_o  = r_out.started;
  assign test_finished_o = r_out.finished;
  assign done_o          = r_out.done;
  assign pass_o          = r_out.done & r_pass;

endmodule

// File: tb/tb_lbist_controller.sv
// Bench for lbist_controller: two instances (with and without warm-up) share
// stimulus; a sequence-offset model predicts every cycle's outputs, the
// stimulus side queues the predictions and a monitor compares them.
module tb_lbist_controller;

  localparam logic [31:0] G = 32'hA5C3_1E0F;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        abort_i = 1'b0;
  logic [31:0] misr_sig_i = G;

  logic a_tm, a_ld, a_te, a_mc, a_me, a_bz, a_st, a_fn, a_dn, a_ps;
  logic b_tm, b_ld, b_te, b_mc, b_me, b_bz, b_st, b_fn, b_dn, b_ps;
  logic [9:0] vec_a, vec_b;

  assign vec_a = {a_tm, a_ld, a_te, a_mc, a_me, a_bz, a_st, a_fn, a_dn, a_ps};
  assign vec_b = {b_tm, b_ld, b_te, b_mc, b_me, b_bz, b_st, b_fn, b_dn, b_ps};

  lbist_controller #(
    .TEST_START(3), .TEST_DURATION(8), .CNT_W(16), .SIG_W(32), .GOLDEN_SIG(G)
  ) dut_a (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .misr_sig_i(misr_sig_i),
    .test_mode_o(a_tm), .tpg_load_o(a_ld), .tpg_en_o(a_te), .misr_clr_o(a_mc),
    .misr_en_o(a_me), .busy_o(a_bz), .test_started_o(a_st), .test_finished_o(a_fn),
    .done_o(a_dn), .pass_o(a_ps)
  );

  lbist_controller #(
    .TEST_START(0), .TEST_DURATION(1), .CNT_W(16), .SIG_W(32), .GOLDEN_SIG(G)
  ) dut_b (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i), .misr_sig_i(misr_sig_i),
    .test_mode_o(b_tm), .tpg_load_o(b_ld), .tpg_en_o(b_te), .misr_clr_o(b_mc),
    .misr_en_o(b_me), .busy_o(b_bz), .test_started_o(b_st), .test_finished_o(b_fn),
    .done_o(b_dn), .pass_o(b_ps)
  );

  always #5 clk = ~clk;

  // Reference model: per instance, the offset t within a test sequence
  // (0 = idle, 1 = INIT, L = 4+TS+TD = DONE) and the latched verdict.
  int m_ts[2] = '{3, 0};
  int m_td[2] = '{8, 1};
  int m_t[2]  = '{0, 0};
  bit m_pass[2] = '{0, 0};

  typedef struct {
    logic [9:0] a;
    logic [9:0] b;
    int         cyc;
  } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  task automatic check(input string name, input int c, input logic [9:0] got,
                       input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", name, c, got, exp);
    end
  endtask

  function automatic logic [9:0] model_out(int i);
    int t, ts, td, len;
    logic tm, ld, te, mc, me, bz, st, fn, dn, ps;
    t   = m_t[i];
    ts  = m_ts[i];
    td  = m_td[i];
    len = 4 + ts + td;
    tm = (t >= 1) && (t <= len - 2);
    ld = (t == 1);
    te = (t >= 2) && (t <= 1 + ts + td);
    mc = (t == 1);
    me = (t >= 2 + ts) && (t <= 2 + ts + td);
    bz = (t >= 1) && (t <= len - 1);
    st = (t >= 2);
    fn = (t >= len - 2);
    dn = (t == len);
    ps = dn && m_pass[i];
    return {tm, ld, te, mc, me, bz, st, fn, dn, ps};
  endfunction

  // Advance one instance's model by the clock edge just taken.
  task automatic model_step(input int i);
    int len;
    len = 4 + m_ts[i] + m_td[i];
    if (rst || abort_i) begin
      m_t[i]    = 0;
      m_pass[i] = 1'b0;
    end else if ((m_t[i] == 0) || (m_t[i] == len)) begin
      if (start_i) begin
        m_t[i]    = 1;
        m_pass[i] = 1'b0;
      end
    end else begin
      if (m_t[i] == len - 1) m_pass[i] = (misr_sig_i == G);
      m_t[i] = m_t[i] + 1;
    end
  endtask

  // Apply inputs for one cycle, take the edge, predict and queue the outputs.
  task automatic step(input logic s, input logic a, input logic [31:0] sig, input bit rst_mid);
    exp_t e;
    start_i    = s;
    abort_i    = a;
    misr_sig_i = sig;
    @(posedge clk);
    #1;
    cyc++;
    model_step(0);
    model_step(1);
    if (rst_mid) begin
      #1 rst = 1'b1;
      #1;
      check("async_rst_a", cyc, vec_a, 10'd0);
      check("async_rst_b", cyc, vec_b, 10'd0);
      m_t    = '{0, 0};
      m_pass = '{0, 0};
    end
    e.a   = model_out(0);
    e.b   = model_out(1);
    e.cyc = cyc;
    sb_q.push_back(e);
  endtask

  // Monitor: compare the DUT against the queued prediction mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("out_a", e.cyc, vec_a, e.a);
        check("out_b", e.cyc, vec_b, e.b);
      end
    end
  end

  initial begin
    logic [31:0] sig;
    // Reset
    step(1'b0, 1'b0, G, 1'b0);
    step(1'b0, 1'b0, G, 1'b0);
    #1 rst = 1'b0;
    step(1'b0, 1'b0, G, 1'b0);

    // Full run with matching signature
    step(1'b1, 1'b0, G, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b0, 1'b0, G, 1'b0);

    // Restart from DONE with a signature one bit off
    step(1'b1, 1'b0, G ^ 32'd1, 1'b0);
    for (int i = 0; i < 18; i++) step(1'b0, 1'b0, G ^ 32'd1, 1'b0);

    // Abort in the middle of RUN, then a fresh full sequence
    step(1'b1, 1'b0, G, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, G, 1'b0);
    step(1'b0, 1'b1, G, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, G, 1'b0);
    step(1'b1, 1'b0, G, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, G, 1'b0);

    // Start held high: no mid-run restart, DONE for one cycle, then INIT
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, G, 1'b0);

    // Asynchronous reset in the middle of warm-up
    step(1'b0, 1'b1, G, 1'b0);
    step(1'b1, 1'b0, G, 1'b0);
    step(1'b0, 1'b0, G, 1'b0);
    step(1'b0, 1'b0, G, 1'b1);
    step(1'b0, 1'b0, G, 1'b0);
    #1 rst = 1'b0;
    step(1'b0, 1'b0, G, 1'b0);
    step(1'b1, 1'b0, G, 1'b0);
    for (int i = 0; i < 17; i++) step(1'b0, 1'b0, G, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      sig = ($urandom_range(0, 1) == 1) ? G : (G ^ (32'd1 << $urandom_range(0, 31)));
      step(($urandom_range(0, 7) == 0), ($urandom_range(0, 39) == 0), sig, 1'b0);
    end

    @(negedge clk);
    #1;
    check("sb_drain", cyc, 10'(sb_q.size()), 10'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
